// File: rtl/dec3_8_strobe.sv
// dec3_8_strobe: sequential 3-to-8 decoder with timed strobe and idle gap.
// Accepts a 3-bit code via ready/valid, drives the matching one-hot line for
// HOLD cycles, then forces GAP all-zero cycles before accepting again.
module dec3_8_strobe #(
  parameter int unsigned HOLD = 4,  // strobe length in cycles, 1..255
  parameter int unsigned GAP  = 1   // idle cycles after each strobe, 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out_onehot,
  output logic       out_active,
  output logic [2:0] last_code,
  output logic [7:0] strobe_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);
  localparam logic [7:0] GAP_LD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t     state;
  logic [7:0] cnt;
  logic       xfer;

  // Ready depends only on registered state and reset, never on in_valid/in_code.
  assign in_ready = (state == S_IDLE) && !rst;
  assign xfer     = in_valid && in_ready;

  // Strobe sequencer: accept, hold one-hot for HOLD cycles, then idle for GAP cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      out_onehot   <= '0;
      out_active   <= 1'b0;
      last_code    <= '0;
      strobe_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_onehot <= '0;
          out_active <= 1'b0;
          if (xfer) begin
            last_code  <= in_code;
            cnt        <= HOLD_LD;
            out_onehot <= 8'b1 << in_code;
            out_active <= 1'b1;
            state      <= S_HOLD;
            if (strobe_count != 8'hFF) begin
              strobe_count <= strobe_count + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (cnt == 8'd0) begin
            out_onehot <= '0;
            out_active <= 1'b0;
            if (GAP > 0) begin
              state <= S_GAP;
              cnt   <= GAP_LD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_GAP: begin
          out_onehot <= '0;
          out_active <= 1'b0;
          if (cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          out_onehot <= '0;
          out_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dec3_8_strobe.md
# dec3_8_strobe

Sequential 3-to-8 decoder: the receive end of the 8:3 priority-encoder path. It accepts a 3-bit code plus valid from an encoder stage through a ready/valid handshake and drives the matching one-hot line for a programmable number of cycles. The strobe is followed by a programmable idle gap. It sits between the encoder output bus and downstream one-hot consumers (line strobes, LED/select drivers) that need a clean, timed, glitch-free select.

## Interface
Parameters:
- HOLD, 4: cycles the one-hot output is asserted per accepted code; legal 1..255.
- GAP, 1: forced all-zero cycles after each strobe before the next accept; legal 0..255.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  encoder code valid (encoder's Valid).
- in_code  in  3  encoded index 0..7 (encoder's Y).
- in_ready  out  1  block can accept; a transfer occurs on a rising edge with in_valid && in_ready.
- out_onehot  out  8  registered one-hot select; bit in_code set during strobe, else 8'h00.
- out_active  out  1  high exactly while out_onehot is non-zero.
- last_code  out  3  code of most recent accepted transfer.
- strobe_count  out  8  accepted transfers since reset, saturating at 255.

## Operation
- Reset values: out_onehot = 8'h00, out_active = 0, last_code = 0, strobe_count = 0, state = IDLE, counter = 0.
- in_ready = (state == IDLE) && !rst. It is combinational from registered state only, with no path from in_valid or in_code.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - out_onehot = 0.
  - On transfer: latch in_code into last_code, load counter = HOLD-1, set out_onehot = 8'b1 << in_code, go to HOLD.
  - strobe_count += 1, unless it is already 255.
- HOLD:
  - out_onehot holds its value.
  - Counter decrements each cycle.
  - When counter == 0: clear out_onehot. Then go to GAP with counter = GAP-1 if GAP > 0, else go to IDLE.
- GAP:
  - out_onehot = 0.
  - Counter decrements; at 0, go to IDLE.
- in_valid and in_code are ignored outside IDLE. No queuing and no drop flag; upstream holds data until in_ready.
- in_valid low in IDLE: the block stays in IDLE and all outputs hold.
- in_code is always 0..7, so every accepted code decodes to exactly one bit. X on in_code while in_valid is low is don't-care and is never latched.
- Counter is 8 bits. HOLD-1 and GAP-1 are computed at elaboration and never wrap.

## Timing
- Transfer on the edge ending cycle 0: out_onehot is valid in cycles 1..HOLD, then GAP zero cycles in cycles HOLD+1..HOLD+GAP.
- in_ready is high again in cycle HOLD+GAP+1.
- Latency from transfer to output: 1 cycle. Maximum throughput: one code per HOLD+GAP+1 cycles.
- GAP = 0: in_ready returns in cycle HOLD+1, and out_onehot is 0 for at least that 1 IDLE cycle. Back-to-back strobes are never merged.
- Reset mid-HOLD or mid-GAP: at the edge with rst = 1, all registers take their reset values. out_onehot is 0 from the next cycle, and strobe_count and last_code clear.
- in_ready is 0 in any cycle in which rst is high.
- Reset takes priority over a simultaneous transfer: in_valid with rst = 1 is not accepted and not counted.
- strobe_count at 255: further transfers still strobe, and the count stays at 255.

## Test plan
- HOLD=4, GAP=1, reset then in_code=5, in_valid pulse in cycle 0 -> out_onehot=8'h20 in cycles 1-4, 8'h00 in cycle 5, in_ready=1 in cycle 6; last_code=5, strobe_count=1.
- HOLD=4, GAP=1, in_valid held high with codes 0,7,3 presented in turn on each accept -> out_onehot 8'h01, 8'h80, 8'h08, each 4 cycles, with a period of exactly 6 cycles; in_ready is low for 5 of every 6 cycles.
- HOLD=1, GAP=0, in_valid held high with code 2 -> out_onehot alternates 8'h04 / 8'h00 every cycle, never two consecutive 8'h04.
- rst asserted in cycle 2 of a HOLD=4 strobe of code 6 -> out_onehot=8'h00 from cycle 3, strobe_count=0, in_ready=1 the cycle after rst deasserts.
- in_valid asserted while in_ready=0 with a changing in_code -> no effect on out_onehot, last_code, or strobe_count.
- 260 accepted transfers -> strobe_count reads 255 after the 255th and stays at 255; each transfer still produces its strobe.
